// File: rtl/blake2_msg_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | blake2_msg_sched: byte stream -> blake2 block loader and digest streamer    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module blake2_msg_sched #(
  parameter int W    = 32,
  parameter int BB   = 64,
  parameter int LL_W = 64,
  parameter int NN_W = 6
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   start_i,
  input  logic [NN_W-1:0]        cfg_kk_i,
  input  logic [NN_W-1:0]        cfg_nn_i,
  input  logic                   cfg_empty_i,
  input  logic                   in_valid_i,
  input  logic [7:0]             in_data_i,
  input  logic                   in_last_i,
  output logic                   in_ready_o,
  output logic [NN_W-1:0]        core_kk_o,
  output logic [NN_W-1:0]        core_nn_o,
  output logic [BB-1:0]          core_ll_o,
  output logic                   core_first_o,
  output logic                   core_last_o,
  output logic                   core_slow_o,
  output logic                   core_data_v_o,
  output logic [$clog2(BB)-1:0]  core_idx_o,
  output logic [7:0]             core_data_o,
  input  logic                   core_ready_i,
  input  logic                   core_h_v_i,
  input  logic [7:0]             core_h_i,
  output logic                   out_valid_o,
  output logic [7:0]             out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o
);

  localparam int                  c_idx_w    = $clog2(BB);
  localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(BB - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_PAD       = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_RDY  = 3'd4,
    S_H_SKIP    = 3'd5,
    S_H_OUT     = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NN_W-1:0]      r_kk;
  logic [NN_W-1:0]      w_kk_nxt;
  logic [NN_W-1:0]      r_nn;
  logic [NN_W-1:0]      w_nn_nxt;
  logic [c_idx_w-1:0]   r_byte_cnt;
  logic [c_idx_w-1:0]   w_byte_cnt_nxt;
  logic [LL_W-1:0]      r_ll_cnt;
  logic [LL_W-1:0]      w_ll_nxt;
  logic                 r_first;
  logic                 w_first_nxt;
  logic                 r_last;
  logic                 w_last_nxt;
  logic [NN_W-1:0]      r_out_cnt;
  logic [NN_W-1:0]      w_out_cnt_nxt;

  logic                 w_accept;
  logic                 w_pad_beat;
  logic                 w_blk_end;
  logic [c_idx_w-1:0]   w_byte_inc;
  logic [LL_W-1:0]      w_ll_inc;
  logic [LL_W-1:0]      w_ll_now;
  logic                 w_h_phase;
  logic                 w_h_beat;
  logic                 w_h_final;
  logic [NN_W-1:0]      w_nn_cfg;

  assign w_accept   = (r_state == S_LOAD) & in_valid_i & core_ready_i;
  assign w_pad_beat = (r_state == S_PAD) & core_ready_i;
  assign w_blk_end  = (r_byte_cnt == c_last_idx);
  assign w_byte_inc = w_blk_end ? '0 : r_byte_cnt + c_idx_w'(1);

  // Length saturates instead of wrapping; includes the byte being accepted now
  // so the core sees the final total on the last data byte of a full block.
  assign w_ll_inc = (&r_ll_cnt) ? r_ll_cnt : r_ll_cnt + LL_W'(1);
  assign w_ll_now = w_accept ? w_ll_inc : r_ll_cnt;

  // The cycle after the discarded early strobe may already carry digest byte 0,
  // so H_SKIP forwards beats exactly like H_OUT.
  assign w_h_phase = (r_state == S_H_SKIP) | (r_state == S_H_OUT);
  assign w_h_beat  = w_h_phase & core_h_v_i;
  assign w_h_final = w_h_beat & (r_out_cnt == r_nn - NN_W'(1));

  // A zero or oversized digest length would never terminate the output phase.
  assign w_nn_cfg = (cfg_nn_i == '0)         ? NN_W'(1) :
                    (cfg_nn_i > NN_W'(W))    ? NN_W'(W) : cfg_nn_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_kk_nxt       = r_kk;
    w_nn_nxt       = r_nn;
    w_byte_cnt_nxt = r_byte_cnt;
    w_ll_nxt       = r_ll_cnt;
    w_first_nxt    = r_first;
    w_last_nxt     = r_last;
    w_out_cnt_nxt  = r_out_cnt;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_kk_nxt       = cfg_kk_i;
          w_nn_nxt       = w_nn_cfg;
          w_ll_nxt       = '0;
          w_first_nxt    = 1'b1;
          w_last_nxt     = cfg_empty_i;
          w_byte_cnt_nxt = '0;
          w_out_cnt_nxt  = '0;
          w_state_nxt    = cfg_empty_i ? S_PAD : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_byte_cnt_nxt = w_byte_inc;
          w_ll_nxt       = w_ll_now;
          if (in_last_i) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = w_blk_end ? S_WAIT_BUSY : S_PAD;
          end else if (w_blk_end) begin
            w_state_nxt = S_WAIT_BUSY;
          end
        end
      end
      S_PAD: begin
        if (w_pad_beat) begin
          w_byte_cnt_nxt = w_byte_inc;
          if (w_blk_end) begin
            w_state_nxt = S_WAIT_BUSY;
          end
        end
      end
      S_WAIT_BUSY: begin
        // Ready dropping means the core has taken the block into compression.
        if (!core_ready_i) begin
          w_first_nxt = 1'b0;
          w_state_nxt = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (!r_last) begin
          if (core_ready_i) begin
            w_byte_cnt_nxt = '0;
            w_state_nxt    = S_LOAD;
          end
        end else if (core_h_v_i) begin
          w_out_cnt_nxt = '0;
          w_state_nxt   = S_H_SKIP;
        end
      end
      S_H_SKIP, S_H_OUT: begin
        if (w_h_beat) begin
          w_out_cnt_nxt = r_out_cnt + NN_W'(1);
        end
        if (w_h_final) begin
          w_state_nxt = S_IDLE;
        end else if (r_state == S_H_SKIP) begin
          w_state_nxt = S_H_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_kk       <= '0;
      r_nn       <= '0;
      r_byte_cnt <= '0;
      r_ll_cnt   <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_out_cnt  <= '0;
    end else begin
      r_kk       <= w_kk_nxt;
      r_nn       <= w_nn_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_ll_cnt   <= w_ll_nxt;
      r_first    <= w_first_nxt;
      r_last     <= w_last_nxt;
      r_out_cnt  <= w_out_cnt_nxt;
    end
  end

  assign in_ready_o    = (r_state == S_LOAD) & core_ready_i;
  assign core_kk_o     = r_kk;
  assign core_nn_o     = r_nn;
  assign core_first_o  = r_first;
  // The core keeps the flag value of the final byte, so the last flag may rise
  // on the very byte that carries in_last_i.
  assign core_last_o   = r_last | (w_accept & in_last_i);
  assign core_slow_o   = 1'b0;
  assign core_data_v_o = w_accept | w_pad_beat;
  assign core_idx_o    = r_byte_cnt;
  assign core_data_o   = w_accept ? in_data_i : 8'h00;
  assign out_valid_o   = w_h_beat;
  assign out_data_o    = w_h_beat ? core_h_i : 8'h00;
  assign out_last_o    = w_h_final;
  assign busy_o        = (r_state != S_IDLE);

  generate
    if (BB > LL_W) begin : g_ll_zext
      assign core_ll_o = {{(BB - LL_W){1'b0}}, w_ll_now};
    end else if (BB == LL_W) begin : g_ll_same
      assign core_ll_o = w_ll_now;
    end else begin : g_ll_trunc
      assign core_ll_o = w_ll_now[BB-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_blake2_msg_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_blake2_msg_sched: directed bench with a behavioural blake2 core stub     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_blake2_msg_sched;

  logic        clk = 1'b0;
  logic        nreset;
  logic        start_i;
  logic [5:0]  cfg_kk_i;
  logic [5:0]  cfg_nn_i;
  logic        cfg_empty_i;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_last_i;
  logic        in_ready_o;
  logic [5:0]  core_kk_o;
  logic [5:0]  core_nn_o;
  logic [63:0] core_ll_o;
  logic        core_first_o;
  logic        core_last_o;
  logic        core_slow_o;
  logic        core_data_v_o;
  logic [5:0]  core_idx_o;
  logic [7:0]  core_data_o;
  logic        core_ready_i;
  logic        core_h_v_i;
  logic [7:0]  core_h_i;
  logic        out_valid_o;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        busy_o;

  blake2_msg_sched dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .cfg_kk_i(cfg_kk_i),
    .cfg_nn_i(cfg_nn_i), .cfg_empty_i(cfg_empty_i), .in_valid_i(in_valid_i),
    .in_data_i(in_data_i), .in_last_i(in_last_i), .in_ready_o(in_ready_o),
    .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
    .core_first_o(core_first_o), .core_last_o(core_last_o),
    .core_slow_o(core_slow_o), .core_data_v_o(core_data_v_o),
    .core_idx_o(core_idx_o), .core_data_o(core_data_o),
    .core_ready_i(core_ready_i), .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  logic any_out;
  assign any_out = |{in_ready_o, core_kk_o, core_nn_o, core_ll_o, core_first_o,
                     core_last_o, core_slow_o, core_data_v_o, core_idx_o,
                     core_data_o, out_valid_o, out_data_o, out_last_o, busy_o};

  typedef struct packed {
    logic [511:0] data;
    logic         first;
    logic         last;
    logic [63:0]  ll;
    logic [5:0]   kk;
  } blk_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [7:0]  msg [0:255];
  logic [7:0]  dig [0:31];
  logic [7:0]  out_q [$];
  blk_t        blocks [$];
  blk_t        cur;
  logic [5:0]  exp_idx;
  int          dv_cnt, idx_err, ready_viol, out_last_pos, out_last_cnt;
  int          first_out_cyc, strobe_cyc, cur_nn;
  bit          in_ready_seen, gap_en, blk_done, blk_done_last;
  int          m_phase, m_busy, m_di, m_tick;
  bit          m_last;
  logic [255:0] dig_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int data_errs(input logic [511:0] d, input int base, input int n);
    int e;
    logic [7:0] ex;
    e = 0;
    for (int j = 0; j < 64; j++) begin
      ex = (base + j < n) ? msg[base + j] : 8'h00;
      if (d[j*8 +: 8] !== ex) e++;
    end
    return e;
  endfunction

  function automatic int dig_errs(input int nn);
    int e;
    e = 0;
    for (int i = 0; i < nn; i++)
      if (i >= out_q.size() || out_q[i] !== dig[i]) e++;
    return e;
  endfunction

  task automatic load_dig_word();
    for (int i = 0; i < 32; i++) dig[i] = dig_word[255 - 8*i -: 8];
  endtask

  task automatic load_dig_pattern();
    for (int i = 0; i < 32; i++) dig[i] = 8'(8'h10 + i * 5);
  endtask

  task automatic load_msg_pattern();
    for (int i = 0; i < 256; i++) msg[i] = 8'(i * 7 + 3);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core stub: accepts a block, drops ready for a few cycles, then either
  // re-opens for the next block or emits an early strobe plus nn digest bytes.
  initial begin
    core_ready_i = 1'b1; core_h_v_i = 1'b0; core_h_i = 8'h00; m_phase = 0;
    forever begin
      @(posedge clk); #1;
      if (!nreset) begin
        m_phase = 0; core_ready_i = 1'b1; core_h_v_i = 1'b0; core_h_i = 8'h00;
        blk_done = 1'b0;
      end else begin
        case (m_phase)
          0: if (blk_done) begin
               blk_done = 1'b0; m_last = blk_done_last; core_ready_i = 1'b0;
               m_busy = 3; m_phase = 1;
             end
          1: begin
               m_busy--;
               if (m_busy == 0) begin
                 if (m_last) begin
                   core_h_v_i = 1'b1; core_h_i = 8'hEE; strobe_cyc = cyc;
                   m_di = 0; m_tick = 0; m_phase = 2;
                 end else begin
                   core_ready_i = 1'b1; m_phase = 0;
                 end
               end
             end
          default: begin
               m_tick++;
               if (m_di >= cur_nn) begin
                 core_h_v_i = 1'b0; core_h_i = 8'h00; core_ready_i = 1'b1; m_phase = 0;
               end else if (gap_en && (m_tick % 3 == 2)) begin
                 core_h_v_i = 1'b0; core_h_i = 8'h00;
               end else begin
                 core_h_v_i = 1'b1; core_h_i = dig[m_di]; m_di++;
               end
             end
        endcase
      end
    end
  end

  initial begin
    cur = '0; exp_idx = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        cur = '0; exp_idx = '0;
      end else begin
        if (in_ready_o) in_ready_seen = 1'b1;
        if (in_ready_o && !core_ready_i) ready_viol++;
        if (core_data_v_o) begin
          if (core_idx_o != exp_idx) idx_err++;
          exp_idx = core_idx_o + 6'd1;
          cur.data[core_idx_o*8 +: 8] = core_data_o;
          dv_cnt++;
          if (core_idx_o == 6'd63) begin
            cur.first = core_first_o; cur.last = core_last_o;
            cur.ll = core_ll_o; cur.kk = core_kk_o;
            blocks.push_back(cur);
            blk_done_last = core_last_o; blk_done = 1'b1;
            cur = '0;
          end
        end
        if (out_valid_o) begin
          if (first_out_cyc < 0) first_out_cyc = cyc;
          if (out_last_o) begin
            out_last_pos = out_q.size(); out_last_cnt++;
          end
          out_q.push_back(out_data_o);
        end
      end
    end
  end

  task automatic send_msg(input int n, input bit stall, input int stop_at);
    int i, t, guard;
    bit acc;
    i = 0; t = 0; guard = 0;
    while (i < n && i != stop_at) begin
      in_valid_i = !(stall && (t % 3 == 1));
      in_data_i  = msg[i];
      in_last_i  = (i == n - 1);
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      t++;
      if (acc) i++;
      guard++;
      if (guard > 5000) begin
        check("send_timeout", 64'(i), 64'(n));
        break;
      end
    end
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic clear_capture(input int nn, input bit gaps);
    blocks.delete(); out_q.delete();
    dv_cnt = 0; idx_err = 0; ready_viol = 0; in_ready_seen = 1'b0;
    out_last_pos = -1; out_last_cnt = 0; first_out_cyc = -1; strobe_cyc = -100;
    cur_nn = nn; gap_en = gaps;
  endtask

  task automatic issue_start(input int nn, input int kk, input bit empty);
    @(posedge clk); #1;
    start_i = 1'b1; cfg_nn_i = 6'(nn); cfg_kk_i = 6'(kk); cfg_empty_i = empty;
    @(posedge clk); #1;
    start_i = 1'b0; cfg_empty_i = 1'b0;
  endtask

  task automatic run_hash(input int n, input int nn, input int kk, input bit empty, input bit stall);
    int g;
    clear_capture(nn, stall);
    issue_start(nn, kk, empty);
    if (!empty) send_msg(n, stall, -1);
    g = 0;
    while (!(out_q.size() >= nn && !busy_o) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    check("hash_done_busy", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_abc(input string tag);
    check({tag, "_blocks"}, 64'(blocks.size()), 64'd1);
    if (blocks.size() > 0) begin
      check({tag, "_first"}, 64'(blocks[0].first), 64'd1);
      check({tag, "_last"}, 64'(blocks[0].last), 64'd1);
      check({tag, "_ll"}, blocks[0].ll, 64'd3);
      check({tag, "_data"}, 64'(data_errs(blocks[0].data, 0, 3)), 64'd0);
    end
    check({tag, "_dv_cnt"}, 64'(dv_cnt), 64'd64);
    check({tag, "_out_cnt"}, 64'(out_q.size()), 64'd32);
    if (out_q.size() >= 4)
      check({tag, "_dig_word0"}, 64'({out_q[0], out_q[1], out_q[2], out_q[3]}), 64'h508c5e8c);
    check({tag, "_dig_errs"}, 64'(dig_errs(32)), 64'd0);
    check({tag, "_last_pos"}, 64'(out_last_pos), 64'd31);
    check({tag, "_last_cnt"}, 64'(out_last_cnt), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    nreset = 1'b0; start_i = 1'b0; cfg_kk_i = '0; cfg_nn_i = '0; cfg_empty_i = 1'b0;
    in_valid_i = 1'b0; in_data_i = '0; in_last_i = 1'b0;
    clear_capture(32, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 64'(any_out), 64'd0);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_in_ready", 64'(in_ready_o), 64'd0);

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    dig_word = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
    load_dig_word();
    run_hash(3, 32, 0, 1'b0, 1'b0);
    check_abc("abc");
    check("abc_latency", 64'(first_out_cyc - strobe_cyc), 64'd1);

    // empty message
    dig_word = 256'h69217a3079908094e11121d042354a7c1f55b6482ca1a51e1b250dfd1ed0eef9;
    load_dig_word();
    run_hash(0, 32, 0, 1'b1, 1'b0);
    check("empty_blocks", 64'(blocks.size()), 64'd1);
    if (blocks.size() > 0) begin
      check("empty_ll", blocks[0].ll, 64'd0);
      check("empty_first", 64'(blocks[0].first), 64'd1);
      check("empty_last", 64'(blocks[0].last), 64'd1);
      check("empty_data", 64'(data_errs(blocks[0].data, 0, 0)), 64'd0);
    end
    check("empty_in_ready", 64'(in_ready_seen), 64'd0);
    if (out_q.size() >= 4)
      check("empty_dig_word0", 64'({out_q[0], out_q[1], out_q[2], out_q[3]}), 64'h69217a30);
    check("empty_dig_errs", 64'(dig_errs(32)), 64'd0);

    // exactly one full block, keyed config passthrough
    load_msg_pattern();
    load_dig_pattern();
    run_hash(64, 32, 3, 1'b0, 1'b0);
    check("b64_blocks", 64'(blocks.size()), 64'd1);
    check("b64_dv_cnt", 64'(dv_cnt), 64'd64);
    if (blocks.size() > 0) begin
      check("b64_ll", blocks[0].ll, 64'd64);
      check("b64_last", 64'(blocks[0].last), 64'd1);
      check("b64_kk", 64'(blocks[0].kk), 64'd3);
      check("b64_data", 64'(data_errs(blocks[0].data, 0, 64)), 64'd0);
    end
    check("b64_dig_errs", 64'(dig_errs(32)), 64'd0);

    // 65 bytes: full block then a padded one
    run_hash(65, 32, 0, 1'b0, 1'b0);
    check("b65_blocks", 64'(blocks.size()), 64'd2);
    check("b65_dv_cnt", 64'(dv_cnt), 64'd128);
    check("b65_ready_viol", 64'(ready_viol), 64'd0);
    if (blocks.size() > 1) begin
      check("b65_b0_first", 64'(blocks[0].first), 64'd1);
      check("b65_b0_last", 64'(blocks[0].last), 64'd0);
      check("b65_b0_data", 64'(data_errs(blocks[0].data, 0, 65)), 64'd0);
      check("b65_b1_first", 64'(blocks[1].first), 64'd0);
      check("b65_b1_last", 64'(blocks[1].last), 64'd1);
      check("b65_b1_ll", blocks[1].ll, 64'd65);
      check("b65_b1_data", 64'(data_errs(blocks[1].data, 64, 65)), 64'd0);
    end
    check("b65_dig_errs", 64'(dig_errs(32)), 64'd0);

    // nn=16 with input stalls and gaps in the core's digest strobe
    run_hash(10, 16, 0, 1'b0, 1'b1);
    check("nn16_idx_err", 64'(idx_err), 64'd0);
    check("nn16_out_cnt", 64'(out_q.size()), 64'd16);
    if (out_q.size() > 0) check("nn16_first_byte", 64'(out_q[0]), 64'(dig[0]));
    check("nn16_dig_errs", 64'(dig_errs(16)), 64'd0);
    check("nn16_last_pos", 64'(out_last_pos), 64'd15);
    if (blocks.size() > 0) check("nn16_data", 64'(data_errs(blocks[0].data, 0, 10)), 64'd0);

    // asynchronous reset in the middle of a load
    clear_capture(32, 1'b0);
    issue_start(32, 5, 1'b0);
    send_msg(40, 1'b0, 21);
    in_valid_i = 1'b1; in_data_i = msg[21]; in_last_i = 1'b0;
    @(negedge clk);
    check("pre_rst_dv", 64'(core_data_v_o), 64'd1);
    check("pre_rst_idx", 64'(core_idx_o), 64'd21);
    #2 nreset = 1'b0;
    #1 check("async_rst_outputs", 64'(any_out), 64'd0);
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    dig_word = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
    load_dig_word();
    run_hash(3, 32, 0, 1'b0, 1'b0);
    check_abc("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
